// File: rtl/demux_load_ctrl.sv
// demux_load_ctrl
//   Fills the 16 neuron-input lanes of the autoencoder datapath from a single
//   DATA_W-bit stream. Each accepted beat lands in the lane named by the
//   internal select counter. The completed frame is then held and offered to
//   the downstream layer under a valid/ready handshake.
//
// Optional build macro:
//   LOAD_CTRL_PARTIAL_EN - honour in_last for short frames. Lanes beyond the
//                          last written beat are cleared on the closing edge.
//
// Ports:
//   clk, rst_n            rising-edge clock, synchronous active-low reset
//   in_data/in_valid      stream beat and its valid flag
//   in_ready              high while filling (a beat is accepted when in_valid)
//   in_last               final beat of a short frame (partial builds only)
//   output_1..output_16   lane registers; lane k is written at select == k-1
//   select                index of the next lane to be written
//   frame_valid           frame held and stable
//   frame_ready           consumer takes the held frame
//   frame_beats           beats written in the held frame (1..16)
module demux_load_ctrl #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_last,
    output logic [DATA_W-1:0] output_1,
    output logic [DATA_W-1:0] output_2,
    output logic [DATA_W-1:0] output_3,
    output logic [DATA_W-1:0] output_4,
    output logic [DATA_W-1:0] output_5,
    output logic [DATA_W-1:0] output_6,
    output logic [DATA_W-1:0] output_7,
    output logic [DATA_W-1:0] output_8,
    output logic [DATA_W-1:0] output_9,
    output logic [DATA_W-1:0] output_10,
    output logic [DATA_W-1:0] output_11,
    output logic [DATA_W-1:0] output_12,
    output logic [DATA_W-1:0] output_13,
    output logic [DATA_W-1:0] output_14,
    output logic [DATA_W-1:0] output_15,
    output logic [DATA_W-1:0] output_16,
    output logic [3:0]        select,
    output logic              frame_valid,
    input  logic              frame_ready,
    output logic [4:0]        frame_beats
);

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] lane [16];
    logic [3:0]        sel;
    logic [4:0]        beats;
    logic              accept;
    logic              last_beat;

    // Handshake flags decode the registered state only.
    assign in_ready    = (state == FILL);
    assign frame_valid = (state == HOLD);
    assign accept      = in_valid && (state == FILL);

`ifdef LOAD_CTRL_PARTIAL_EN
    assign last_beat = accept && ((sel == 4'd15) || in_last);
`else
    logic unused_in_last;
    assign unused_in_last = in_last;
    assign last_beat      = accept && (sel == 4'd15);
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= FILL;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            FILL: if (last_beat)   state_nxt = HOLD;
            HOLD: if (frame_ready) state_nxt = FILL;
            default:               state_nxt = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sel   <= '0;
            beats <= '0;
            for (int unsigned i = 0; i < 16; i++) begin
                lane[i] <= '0;
            end
        end else if (accept) begin
            lane[sel] <= in_data;
            if (last_beat) begin
                // select wraps to 0 only when the frame closes.
                sel   <= '0;
                beats <= {1'b0, sel} + 5'd1;
`ifdef LOAD_CTRL_PARTIAL_EN
                for (int unsigned i = 0; i < 16; i++) begin
                    if (4'(i) > sel) begin
                        lane[i] <= '0;
                    end
                end
`endif
            end else begin
                sel <= sel + 4'd1;
            end
        end
    end

    assign select      = sel;
    assign frame_beats = beats;

    assign output_1  = lane[0];
    assign output_2  = lane[1];
    assign output_3  = lane[2];
    assign output_4  = lane[3];
    assign output_5  = lane[4];
    assign output_6  = lane[5];
    assign output_7  = lane[6];
    assign output_8  = lane[7];
    assign output_9  = lane[8];
    assign output_10 = lane[9];
    assign output_11 = lane[10];
    assign output_12 = lane[11];
    assign output_13 = lane[12];
    assign output_14 = lane[13];
    assign output_15 = lane[14];
    assign output_16 = lane[15];

endmodule

// File: tb/tb_demux_load_ctrl.sv
// tb_demux_load_ctrl
//   Directed self-checking bench for demux_load_ctrl. Inputs change and outputs
//   are sampled 1 time unit after each rising edge.
//   Partial-frame expectations follow LOAD_CTRL_PARTIAL_EN.
module tb_demux_load_ctrl;

    logic        clk;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        in_last;
    logic [15:0] outs [16];
    logic [3:0]  select;
    logic        frame_valid;
    logic        frame_ready;
    logic [4:0]  frame_beats;

    int n_checks;
    int n_errors;

    demux_load_ctrl #(.DATA_W(16)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_last     (in_last),
        .output_1    (outs[0]),
        .output_2    (outs[1]),
        .output_3    (outs[2]),
        .output_4    (outs[3]),
        .output_5    (outs[4]),
        .output_6    (outs[5]),
        .output_7    (outs[6]),
        .output_8    (outs[7]),
        .output_9    (outs[8]),
        .output_10   (outs[9]),
        .output_11   (outs[10]),
        .output_12   (outs[11]),
        .output_13   (outs[12]),
        .output_14   (outs[13]),
        .output_15   (outs[14]),
        .output_16   (outs[15]),
        .select      (select),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_beats (frame_beats)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        in_data     = '0;
        repeat (3) tick();
        rst_n = 1'b1;
    endtask

    task automatic send_beat(input logic [15:0] d, input logic last);
        in_data  = d;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (outs[i] !== 16'h0000) begin
                n_errors++;
                $display("FAIL reset_lane%0d got %h expected 0000", i + 1, outs[i]);
            end
        end
        n_checks++;
        if (select !== 4'd0) begin
            n_errors++;
            $display("FAIL reset_select got %0d expected 0", select);
        end
        n_checks++;
        if (frame_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_frame_valid got %b expected 0", frame_valid);
        end
        n_checks++;
        if (frame_beats !== 5'd0) begin
            n_errors++;
            $display("FAIL reset_frame_beats got %0d expected 0", frame_beats);
        end
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_in_ready got %b expected 1", in_ready);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        frame_ready = 1'b1;
        in_valid    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            n_checks++;
            if (frame_valid !== 1'b0 || in_ready !== 1'b1 || select !== 4'(k)) begin
                n_errors++;
                $display("FAIL b2b_fill_beat%0d got valid=%b ready=%b sel=%0d expected 0/1/%0d",
                         k, frame_valid, in_ready, select, k);
            end
            in_data = 16'(16'h0100 + k);
            tick();
        end
        // Next frame's first beat presented while the frame is held.
        in_data = 16'h0200;
        n_checks++;
        if (frame_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_errors++;
            $display("FAIL b2b_hold got valid=%b ready=%b expected 1/0", frame_valid, in_ready);
        end
        n_checks++;
        if (frame_beats !== 5'd16) begin
            n_errors++;
            $display("FAIL b2b_frame_beats got %0d expected 16", frame_beats);
        end
        n_checks++;
        if (select !== 4'd0) begin
            n_errors++;
            $display("FAIL b2b_hold_select got %0d expected 0", select);
        end
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (outs[i] !== 16'(16'h0100 + i)) begin
                n_errors++;
                $display("FAIL b2b_lane%0d got %h expected %h", i + 1, outs[i], 16'(16'h0100 + i));
            end
        end
        tick();
        n_checks++;
        if (frame_valid !== 1'b0 || in_ready !== 1'b1 || select !== 4'd0 || outs[0] !== 16'h0100) begin
            n_errors++;
            $display("FAIL b2b_release got valid=%b ready=%b sel=%0d lane1=%h expected 0/1/0/0100",
                     frame_valid, in_ready, select, outs[0]);
        end
        tick();
        n_checks++;
        if (select !== 4'd1 || outs[0] !== 16'h0200 || outs[1] !== 16'h0101) begin
            n_errors++;
            $display("FAIL b2b_next_first got sel=%0d lane1=%h lane2=%h expected 1/0200/0101",
                     select, outs[0], outs[1]);
        end
        in_valid    = 1'b0;
        frame_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        frame_ready = 1'b0;
        in_valid    = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_data = 16'(16'h2000 + k);
            tick();
        end
        in_data = 16'hBEEF;
        for (int c = 0; c < 10; c++) begin
            n_checks++;
            if (in_ready !== 1'b0 || frame_valid !== 1'b1 || frame_beats !== 5'd16 ||
                select !== 4'd0 || outs[0] !== 16'h2000 || outs[15] !== 16'h200F) begin
                n_errors++;
                $display("FAIL bp_hold_cycle%0d got ready=%b valid=%b beats=%0d sel=%0d l1=%h l16=%h expected 0/1/16/0/2000/200f",
                         c, in_ready, frame_valid, frame_beats, select, outs[0], outs[15]);
            end
            tick();
        end
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        tick();
        n_checks++;
        if (outs[0] !== 16'hBEEF || outs[1] !== 16'h2001 || select !== 4'd1) begin
            n_errors++;
            $display("FAIL bp_17th_beat got l1=%h l2=%h sel=%0d expected beef/2001/1",
                     outs[0], outs[1], select);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_gaps();
        int accepts;
        int cyc;
        do_reset();
        frame_ready = 1'b1;   // no effect while filling
        accepts = 0;
        cyc     = 0;
        while (accepts < 16 && cyc < 64) begin
            in_valid = (cyc % 2 == 0);
            in_data  = 16'(16'h3000 + accepts);
            tick();
            if (cyc % 2 == 0) accepts++;
            cyc++;
            n_checks++;
            if (select !== ((accepts == 16) ? 4'd0 : 4'(accepts)) ||
                frame_valid !== (accepts == 16)) begin
                n_errors++;
                $display("FAIL gaps_cycle%0d got sel=%0d valid=%b after %0d accepts",
                         cyc, select, frame_valid, accepts);
            end
        end
        in_valid = 1'b0;
        n_checks++;
        if (frame_beats !== 5'd16 || outs[15] !== 16'h300F || outs[7] !== 16'h3007) begin
            n_errors++;
            $display("FAIL gaps_frame got beats=%0d l16=%h l8=%h expected 16/300f/3007",
                     frame_beats, outs[15], outs[7]);
        end
        frame_ready = 1'b0;
    endtask

    task automatic test_partial();
        do_reset();
        frame_ready = 1'b0;
        for (int k = 0; k < 16; k++) send_beat(16'hFFFF, 1'b0);
        frame_ready = 1'b1;
        tick();
        frame_ready = 1'b0;
        for (int k = 0; k < 5; k++) send_beat(16'(16'h4000 + k), (k == 4));
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (outs[i] !== 16'(16'h4000 + i)) begin
                n_errors++;
                $display("FAIL partial_lane%0d got %h expected %h", i + 1, outs[i], 16'(16'h4000 + i));
            end
        end
`ifdef LOAD_CTRL_PARTIAL_EN
        for (int i = 5; i < 16; i++) begin
            n_checks++;
            if (outs[i] !== 16'h0000) begin
                n_errors++;
                $display("FAIL partial_cleared_lane%0d got %h expected 0000", i + 1, outs[i]);
            end
        end
        n_checks++;
        if (frame_valid !== 1'b1 || frame_beats !== 5'd5 || select !== 4'd0) begin
            n_errors++;
            $display("FAIL partial_frame got valid=%b beats=%0d sel=%0d expected 1/5/0",
                     frame_valid, frame_beats, select);
        end
`else
        n_checks++;
        if (outs[5] !== 16'hFFFF || outs[15] !== 16'hFFFF) begin
            n_errors++;
            $display("FAIL partial_ignored_lanes got l6=%h l16=%h expected ffff/ffff", outs[5], outs[15]);
        end
        n_checks++;
        if (frame_valid !== 1'b0 || select !== 4'd5 || frame_beats !== 5'd16) begin
            n_errors++;
            $display("FAIL partial_ignored got valid=%b sel=%0d beats=%0d expected 0/5/16",
                     frame_valid, select, frame_beats);
        end
`endif
    endtask

    task automatic test_mid_reset();
        do_reset();
        for (int k = 0; k < 7; k++) send_beat(16'(16'h5000 + k), 1'b0);
        n_checks++;
        if (select !== 4'd7 || outs[6] !== 16'h5006) begin
            n_errors++;
            $display("FAIL midrst_pre got sel=%0d l7=%h expected 7/5006", select, outs[6]);
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++;
        if (select !== 4'd0 || frame_valid !== 1'b0 || outs[0] !== 16'h0000 || outs[6] !== 16'h0000) begin
            n_errors++;
            $display("FAIL midrst_post got sel=%0d valid=%b l1=%h l7=%h expected 0/0/0000/0000",
                     select, frame_valid, outs[0], outs[6]);
        end
        for (int c = 0; c < 5; c++) begin
            tick();
            n_checks++;
            if (frame_valid !== 1'b0 || in_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL midrst_idle%0d got valid=%b ready=%b expected 0/1", c, frame_valid, in_ready);
            end
        end
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        frame_ready = 1'b0;
        in_data     = '0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_gaps();
        test_partial();
        test_mid_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
